// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding,
// SRAM geometry and the half-word address helper.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam int          SRAM_AW           = 18;
  localparam int          SRAM_DW           = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  // Word index plus half select gives the SRAM half-word address.
  function automatic logic [SRAM_AW-1:0] half_addr(input logic [SRAM_AW-2:0] idx,
                                                   input logic hi);
    return {idx, hi};
  endfunction

endpackage

// File: rtl/sram_controller.sv
// Serves one 32-bit word per request over a 16-bit SRAM as two half-word
// accesses (low half first), freezing the pipeline through ready meanwhile.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic               rdEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  localparam int            CW       = $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  mem_state_t          r_state, w_next_state;
  logic [CW-1:0]       r_cnt, w_next_cnt;
  logic                r_is_write;
  logic [31:0]         r_wdata;
  logic [SRAM_AW-2:0]  r_idx;
  logic [31:0]         r_read_data;
  logic                r_we_n;
  logic [SRAM_AW-1:0]  r_addr;
  logic                r_dq_oe;
  logic [SRAM_DW-1:0]  r_dq_out;

  logic                w_req, w_half_end, w_op_write;
  logic [SRAM_AW-2:0]  w_idx, w_op_idx;
  logic [31:0]         w_op_wdata;
  logic                w_next_we_n, w_next_dq_oe;
  logic [SRAM_AW-1:0]  w_next_addr;
  logic [SRAM_DW-1:0]  w_next_dq_out;

  assign w_req      = wrEn | rdEn;
  assign w_half_end = (r_cnt == LAST_CNT);
  assign w_idx      = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

  // The access being entered from IDLE takes its operands straight from the pipeline.
  assign w_op_write = (r_state == ST_IDLE) ? wrEn      : r_is_write;
  assign w_op_idx   = (r_state == ST_IDLE) ? w_idx     : r_idx;
  assign w_op_wdata = (r_state == ST_IDLE) ? writeData : r_wdata;

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state, counter and ready decode
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    ready        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = ~w_req;
        if (w_req) begin
          w_next_state = ST_LOW;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = '0;
        end
      end
      ST_LOW: begin
        if (w_half_end) begin
          w_next_state = ST_HIGH;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = r_cnt + 1'b1;
        end
      end
      ST_HIGH: begin
        if (w_half_end) begin
          w_next_state = ST_DONE;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt   = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        ready        = 1'b1;
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Pin values for the coming cycle; WE_N rises on the last cycle of each write half.
  always_comb begin
    w_next_we_n   = 1'b1;
    w_next_dq_oe  = 1'b0;
    w_next_dq_out = r_dq_out;
    w_next_addr   = r_addr;
    case (w_next_state)
      ST_LOW: begin
        w_next_addr   = half_addr(w_op_idx, 1'b0);
        w_next_dq_oe  = w_op_write;
        w_next_dq_out = w_op_wdata[15:0];
        w_next_we_n   = ~(w_op_write && (w_next_cnt != LAST_CNT));
      end
      ST_HIGH: begin
        w_next_addr   = half_addr(w_op_idx, 1'b1);
        w_next_dq_oe  = w_op_write;
        w_next_dq_out = w_op_wdata[31:16];
        w_next_we_n   = ~(w_op_write && (w_next_cnt != LAST_CNT));
      end
      default: begin
        w_next_we_n  = 1'b1;
        w_next_dq_oe = 1'b0;
      end
    endcase
  end

  // Pin registers, request latch and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_write  <= 1'b0;
      r_wdata     <= '0;
      r_idx       <= '0;
      r_read_data <= '0;
      r_we_n      <= 1'b1;
      r_addr      <= '0;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
    end else begin
      r_we_n   <= w_next_we_n;
      r_addr   <= w_next_addr;
      r_dq_oe  <= w_next_dq_oe;
      r_dq_out <= w_next_dq_out;
      if (r_state == ST_IDLE && w_req) begin
        r_is_write <= wrEn;
        r_wdata    <= writeData;
        r_idx      <= w_idx;
      end
      if (!r_is_write && w_half_end && r_state == ST_LOW) begin
        r_read_data[15:0] <= SRAM_DQ;
      end
      if (!r_is_write && w_half_end && r_state == ST_HIGH) begin
        r_read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  assign readData  = r_read_data;
  assign SRAM_ADDR = r_addr;
  assign SRAM_WE_N = r_we_n;
  assign SRAM_DQ   = r_dq_oe ? r_dq_out : {SRAM_DW{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule
